ascii_save_capture: RTL and testbench

- Counterpart to the ASCII file loader: captures bytes the ACIA transmits (BASIC SAVE / LIST output) into on-chip RAM.
- Serves the captured bytes to the HPS through the ioctl upload read handshake, so a program can be saved as a .TXT/.BAS file.
- Sits in the emu level beside hps_io, clocked by clk_sys.

---
 rtl/ascii_save_capture_if.sv | 30 +++
 rtl/ascii_save_capture.sv | 179 +++++++++++++++++
 tb/tb_ascii_save_capture.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_save_capture_if.sv
// Capture/upload bus between the ACIA-side capture logic, hps_io, and ascii_save_capture.
// The master side drives the requests; the slave (ascii_save_capture) returns data and status.
interface ascii_save_capture_if #(
  parameter int ADDR_W = 14
) ();
  logic              capture_start;
  logic              capture_stop;
  logic [7:0]        tx_data;
  logic              tx_strobe;
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [ADDR_W:0]   ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              capturing;
  logic              overflow;
  logic [ADDR_W:0]   file_size;

  modport master (
    output capture_start, capture_stop, tx_data, tx_strobe,
    output ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, capturing, overflow, file_size
  );

  modport slave (
    input  capture_start, capture_stop, tx_data, tx_strobe,
    input  ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, capturing, overflow, file_size
  );
endinterface

// File: rtl/ascii_save_capture.sv
// Captures ACIA transmit bytes into RAM and serves them to hps_io upload reads; ASCII_SAVE_CRLF_EN adds CR/LF/NUL translation.
// Read data arrives 2 cycles after ioctl_rd with ioctl_wait stalling hps_io; tx bytes are never stalled and are dropped once full.
module ascii_save_capture #(
  parameter int         ADDR_W   = 14,
  parameter logic [7:0] PAD_BYTE = 8'h1A
) (
  input  logic                clk,
  input  logic                n_reset,
  ascii_save_capture_if.slave bus
);

  localparam int unsigned     DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL  = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2,
    S_UPLOAD  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              upload_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   file_size_q;
  logic              overflow_q;
  logic              rd_pend;
  logic [ADDR_W:0]   rd_addr_q;
  logic [7:0]        ram_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              capturing_c;

  logic [7:0] mem [DEPTH];

  logic       start_clr;
  logic       buf_full;
  logic       byte_keep;
  logic [7:0] byte_val;
  logic       strobe_cap;
  logic       wr_en;
  logic       drop_full;
  logic       rd_go;

  // capture_start is honoured everywhere except UPLOAD
  assign start_clr  = bus.capture_start && (state != S_UPLOAD);
  assign buf_full   = (file_size_q == FULL);
  assign strobe_cap = (state == S_CAPTURE) && bus.tx_strobe && !bus.capture_start;

`ifdef ASCII_SAVE_CRLF_EN
  logic last_was_cr;

  always_comb begin
    byte_keep = 1'b1;
    byte_val  = bus.tx_data;
    if (bus.tx_data == 8'h00) begin
      byte_keep = 1'b0;
    end else if (bus.tx_data == 8'h0A && last_was_cr) begin
      byte_keep = 1'b0;
    end else if (bus.tx_data == 8'h0D) begin
      byte_val = 8'h0A;
    end
  end

  // Tracks every strobe, kept or not, so only an LF directly after CR is folded
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_was_cr <= 1'b0;
    end else if (start_clr) begin
      last_was_cr <= 1'b0;
    end else if (strobe_cap) begin
      last_was_cr <= (bus.tx_data == 8'h0D);
    end
  end
`else
  assign byte_keep = 1'b1;
  assign byte_val  = bus.tx_data;
`endif

  assign wr_en     = strobe_cap && byte_keep && !buf_full;
  assign drop_full = strobe_cap && byte_keep && buf_full;
  assign rd_go     = (state == S_UPLOAD) && bus.ioctl_rd && !wait_q && !rd_pend;

  // FSM: state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      upload_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      upload_q <= bus.ioctl_upload;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.capture_start)     state_nxt = S_CAPTURE;
        else if (bus.ioctl_upload) state_nxt = S_UPLOAD;
      end
      S_CAPTURE: begin
        if (bus.capture_start)     state_nxt = S_CAPTURE;
        else if (bus.capture_stop) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.capture_start)                     state_nxt = S_CAPTURE;
        else if (bus.ioctl_upload && !upload_q)    state_nxt = S_UPLOAD;
      end
      S_UPLOAD: begin
        if (!bus.ioctl_upload)     state_nxt = S_HOLD;
      end
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    capturing_c = 1'b0;
    if (state == S_CAPTURE) capturing_c = 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr      <= '0;
      file_size_q <= '0;
      overflow_q  <= 1'b0;
    end else if (start_clr) begin
      wr_ptr      <= '0;
      file_size_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr      <= wr_ptr + 1'b1;
        file_size_q <= file_size_q + 1'b1;
      end
      if (drop_full) overflow_q <= 1'b1;
    end
  end

  // Single-port RAM: writes only in CAPTURE, reads only in UPLOAD
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= byte_val;
    end else if (rd_go) begin
      ram_q <= mem[bus.ioctl_addr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      wait_q    <= 1'b0;
      din_q     <= 8'h00;
    end else begin
      rd_pend <= rd_go;
      if (rd_go) begin
        rd_addr_q <= bus.ioctl_addr;
        wait_q    <= 1'b1;
      end
      // Second cycle: RAM word is in ram_q, pad anything past the captured length
      if (rd_pend) begin
        din_q  <= (rd_addr_q >= file_size_q) ? PAD_BYTE : ram_q;
        wait_q <= 1'b0;
      end
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.capturing  = capturing_c;
  assign bus.overflow   = overflow_q;
  assign bus.file_size  = file_size_q;

endmodule

// File: tb/tb_ascii_save_capture.sv
// Directed bench for ascii_save_capture (ADDR_W=4): upload read data checked by a scoreboard monitor, status checked inline.
module tb_ascii_save_capture;
  localparam int         AW  = 4;
  localparam logic [7:0] PAD = 8'h1A;
`ifdef ASCII_SAVE_CRLF_EN
  localparam logic [7:0] CR_STORED = 8'h0A;
`else
  localparam logic [7:0] CR_STORED = 8'h0D;
`endif

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

  ascii_save_capture_if #(.ADDR_W(AW)) bus ();

  ascii_save_capture #(.ADDR_W(AW), .PAD_BYTE(PAD)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: read data is presented when ioctl_wait falls
  logic wait_prev = 1'b0;
  always @(negedge clk) begin
    if (!n_reset) begin
      wait_prev = 1'b0;
    end else begin
      if (wait_prev && !bus.ioctl_wait) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read_data actual=%0h required=none", bus.ioctl_din);
        end else begin
          chk("ioctl_din", {24'd0, bus.ioctl_din}, {24'd0, exp_q.pop_front()});
        end
      end
      wait_prev = bus.ioctl_wait;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.tx_data   = d;
    bus.tx_strobe = 1'b1;
    tick();
    bus.tx_strobe = 1'b0;
  endtask

  task automatic pulse_start();
    bus.capture_start = 1'b1;
    tick();
    bus.capture_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.capture_stop = 1'b1;
    tick();
    bus.capture_stop = 1'b0;
  endtask

  task automatic do_read(input logic [AW:0] addr, input logic [7:0] exp);
    int n;
    exp_q.push_back(exp);
    bus.ioctl_addr = addr;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
    chk("wait_cycle1", {31'd0, bus.ioctl_wait}, 32'd1);
    tick();
    chk("wait_cycle2", {31'd0, bus.ioctl_wait}, 32'd0);
    n = 0;
    while (bus.ioctl_wait && n < 8) begin
      tick();
      n++;
    end
    if (bus.ioctl_wait) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout actual=1 required=0");
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.capture_start = 1'b0;
    bus.capture_stop  = 1'b0;
    bus.tx_data       = 8'h00;
    bus.tx_strobe     = 1'b0;
    bus.ioctl_upload  = 1'b0;
    bus.ioctl_rd      = 1'b0;
    bus.ioctl_addr    = '0;
    tick();
    tick();
    chk("rst_capturing", {31'd0, bus.capturing}, 32'd0);
    chk("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    chk("rst_wait",      {31'd0, bus.ioctl_wait}, 32'd0);
    chk("rst_din",       {24'd0, bus.ioctl_din}, 32'h00);
    chk("rst_file_size", {27'd0, bus.file_size}, 32'd0);
    n_reset = 1'b1;
    tick();

    // Upload from IDLE serves an empty file
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(5'd0, PAD);
    bus.ioctl_upload = 1'b0;
    tick();

    // Basic capture
    pulse_start();
    chk("cap_capturing", {31'd0, bus.capturing}, 32'd1);
    strobe(8'h31);
    strobe(8'h30);
    strobe(8'h0D);
    chk("cap_size_pre_stop", {27'd0, bus.file_size}, 32'd3);
    pulse_stop();
    chk("stop_capturing", {31'd0, bus.capturing}, 32'd0);
    chk("stop_file_size", {27'd0, bus.file_size}, 32'd3);
    chk("stop_overflow",  {31'd0, bus.overflow},  32'd0);

    bus.ioctl_upload = 1'b1;
    tick();
    do_read(5'd1, 8'h30);
    do_read(5'd3, PAD);
    do_read(5'd2, CR_STORED);
    do_read(5'd0, 8'h31);
    bus.ioctl_upload = 1'b0;
    tick();

    // Same-cycle events
    pulse_start();
    strobe(8'h55);
    bus.capture_start = 1'b1;
    strobe(8'h66);
    bus.capture_start = 1'b0;
    chk("start_with_strobe_size", {27'd0, bus.file_size}, 32'd0);
    strobe(8'h77);
    chk("after_restart_size", {27'd0, bus.file_size}, 32'd1);
    bus.capture_stop = 1'b1;
    strobe(8'h42);
    bus.capture_stop = 1'b0;
    chk("stop_with_strobe_size", {27'd0, bus.file_size}, 32'd2);
    chk("stop_with_strobe_cap",  {31'd0, bus.capturing}, 32'd0);
    strobe(8'h99);
    chk("hold_strobe_size", {27'd0, bus.file_size}, 32'd2);
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(5'd0, 8'h77);
    do_read(5'd1, 8'h42);
    do_read(5'd2, PAD);
    bus.ioctl_upload = 1'b0;
    tick();

    // Overflow
    pulse_start();
    for (int i = 0; i < 18; i++) strobe(8'h41);
    chk("ovf_file_size", {27'd0, bus.file_size}, 32'd16);
    chk("ovf_flag",      {31'd0, bus.overflow},  32'd1);
    pulse_stop();
    bus.ioctl_upload = 1'b1;
    tick();
    pulse_start();
    chk("upload_ignores_start", {31'd0, bus.capturing}, 32'd0);
    chk("upload_keeps_size",    {27'd0, bus.file_size}, 32'd16);
    do_read(5'd15, 8'h41);
    do_read(5'd16, PAD);
    do_read(5'd0, 8'h41);
    bus.ioctl_upload = 1'b0;
    tick();

`ifdef ASCII_SAVE_CRLF_EN
    pulse_start();
    strobe(8'h41);
    strobe(8'h0D);
    strobe(8'h0A);
    strobe(8'h00);
    strobe(8'h42);
    pulse_stop();
    chk("crlf_file_size", {27'd0, bus.file_size}, 32'd3);
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(5'd0, 8'h41);
    do_read(5'd1, 8'h0A);
    do_read(5'd2, 8'h42);
    do_read(5'd3, PAD);
    bus.ioctl_upload = 1'b0;
    tick();
`endif

    // Async reset mid-capture
    pulse_start();
    for (int i = 0; i < 17; i++) strobe(8'h41);
    chk("pre_rst_overflow", {31'd0, bus.overflow}, 32'd1);
    #3;
    n_reset = 1'b0;
    #1;
    chk("async_rst_capturing", {31'd0, bus.capturing}, 32'd0);
    chk("async_rst_file_size", {27'd0, bus.file_size}, 32'd0);
    chk("async_rst_overflow",  {31'd0, bus.overflow},  32'd0);
    tick();
    n_reset = 1'b1;
    tick();
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(5'd0, PAD);
    bus.ioctl_upload = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
